// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: entry layout and widths.
package uart_pkg;

  // Stored entry is {perror, ferror, data[7:0]}.
  localparam int RX_ENTRY_W = 10;
  localparam int PERR_BIT   = 9;
  localparam int FERR_BIT   = 8;
  localparam int ERR_CNT_W  = 8;

  // Pointer width for a power-of-two buffer; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx_valid_edge.sv
// Turns a level-style valid (or done) flag into a one-cycle pulse on its
// rising edge. A level already high when reset releases yields one pulse.
module rx_valid_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic valid_q;

  // Remember last cycle's level so a long-held valid produces one pulse.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= level_i;
  end

  assign pulse_o = level_i & ~valid_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between the UART receiver and its consumer.
// Stores each received byte with its framing/parity flags, optionally drops
// errored bytes (counting them), and flags bytes lost to a full buffer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             Rx_DATA,
  input  logic                   Rx_VALID,
  input  logic                   Rx_FERROR,
  input  logic                   Rx_PERROR,
  input  logic                   rd_en,
  input  logic                   clr_ovf,
  output logic [7:0]             dout,
  output logic                   dout_ferror,
  output logic                   dout_perror,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RX_ENTRY_W-1:0] mem [DEPTH];
  logic [RX_ENTRY_W-1:0] head;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic push, drop, accept, do_push, do_pop, ovf_evt;

  rx_valid_edge u_edge (
    .clk     (clk),
    .rst_n   (reset),
    .level_i (Rx_VALID),
    .pulse_o (push)
  );

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Arbitrate the push/pop pair against the full/empty state.
  always_comb begin
    drop    = DROP_ERR && push && (Rx_FERROR || Rx_PERROR);
    accept  = push && !drop;
    do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    do_push = accept && (!full || do_pop);
    ovf_evt = accept && full && !do_pop;
  end

  // Next pointer, occupancy and sticky status; an event in the same cycle
  // as clr_ovf takes precedence over the clear.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    if (clr_ovf) begin
      ovf_d = 1'b0;
      err_d = '0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (drop && (err_d != '1)) err_d = err_d + ERR_CNT_W'(1);
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; its contents are never observed
  // while empty, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {Rx_PERROR, Rx_FERROR, Rx_DATA};
  end

  // First-word-fall-through read port, forced to zero while empty.
  always_comb begin
    head        = mem[rd_ptr_q];
    dout        = 8'h00;
    dout_ferror = 1'b0;
    dout_perror = 1'b0;
    if (!empty) begin
      dout        = head[7:0];
      dout_ferror = head[FERR_BIT];
      dout_perror = head[PERR_BIT];
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: one instance storing errored bytes and one
// dropping them, driven by the same stimulus and checked every cycle
// against queue-based reference models plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_ferror = 1'b0, rx_perror = 1'b0;
  logic       rd_en = 1'b0, clr_ovf = 1'b0;

  logic [7:0] dout_a, dout_b, err_a, err_b;
  logic       fe_a, fe_b, pe_a, pe_b, empty_a, empty_b, full_a, full_b;
  logic       ovf_a, ovf_b;
  logic [3:0] cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b0)) dut_a (
    .clk(clk), .reset(rst_n), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
    .Rx_FERROR(rx_ferror), .Rx_PERROR(rx_perror), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .dout(dout_a), .dout_ferror(fe_a), .dout_perror(pe_a),
    .empty(empty_a), .full(full_a), .count(cnt_a), .overflow(ovf_a),
    .err_count(err_a)
  );

  uart_rx_fifo #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) dut_b (
    .clk(clk), .reset(rst_n), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
    .Rx_FERROR(rx_ferror), .Rx_PERROR(rx_perror), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .dout(dout_b), .dout_ferror(fe_b), .dout_perror(pe_b),
    .empty(empty_b), .full(full_b), .count(cnt_b), .overflow(ovf_b),
    .err_count(err_b)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference models: a queue per instance, pops before pushes so a full
  // buffer with a simultaneous pop has room for the new byte.
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  bit m_ovfa = 0, m_ovfb = 0, m_prev = 0;
  int m_errb = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit         pushed, bad;
    logic [9:0] ent;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      m_ovfa = 0; m_ovfb = 0; m_errb = 0; m_prev = 0;
    end else begin
      pushed = rx_valid && !m_prev;
      m_prev = rx_valid;
      bad    = rx_ferror || rx_perror;
      ent    = {rx_perror, rx_ferror, rx_data};
      if (rd_en && qa.size() > 0) void'(qa.pop_front());
      if (rd_en && qb.size() > 0) void'(qb.pop_front());
      if (clr_ovf) begin m_ovfa = 0; m_ovfb = 0; m_errb = 0; end
      if (pushed) begin
        if (qa.size() < DEPTH) qa.push_back(ent); else m_ovfa = 1;
        if (bad) m_errb = (m_errb < 255) ? m_errb + 1 : 255;
        else if (qb.size() < DEPTH) qb.push_back(ent);
        else m_ovfb = 1;
      end
    end
  end

  // Compare both instances against their models away from the clock edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("a_count", cnt_a, qa.size());
      check("a_empty", empty_a, qa.size() == 0);
      check("a_full", full_a, qa.size() == DEPTH);
      check("a_ovf", ovf_a, m_ovfa);
      check("a_err", err_a, 0);
      if (qa.size() > 0) begin
        check("a_dout", dout_a, qa[0][7:0]);
        check("a_ferr", fe_a, qa[0][8]);
        check("a_perr", pe_a, qa[0][9]);
      end
      check("b_count", cnt_b, qb.size());
      check("b_empty", empty_b, qb.size() == 0);
      check("b_full", full_b, qb.size() == DEPTH);
      check("b_ovf", ovf_b, m_ovfb);
      check("b_err", err_b, m_errb);
      if (qb.size() > 0) begin
        check("b_dout", dout_b, qb[0][7:0]);
        check("b_ferr", fe_b, qb[0][8]);
        check("b_perr", pe_b, qb[0][9]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic f, input logic p);
    rx_data = d; rx_ferror = f; rx_perror = p; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    #1;
    check("rst_count", cnt_a, 0);
    check("rst_empty", empty_a, 1);
    check("rst_full", full_a, 0);
    check("rst_dout", dout_a, 8'h00);
    check("rst_ovf", ovf_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Long-held valid yields exactly one entry.
    rx_data = 8'hA5; rx_valid = 1'b1;
    repeat (40) tick();
    check("hold_count", cnt_a, 1);
    check("hold_dout", dout_a, 8'hA5);
    check("hold_flags", {fe_a, pe_a}, 2'b00);
    rx_valid = 1'b0;
    tick();
    pop();
    check("hold_empty", empty_a, 1);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 9; i++) push_byte(8'(i), 1'b0, 1'b0);
    check("ovf_full", full_a, 1);
    check("ovf_flag", ovf_a, 1);
    check("ovf_count", cnt_a, 8);
    for (int i = 1; i <= 8; i++) begin
      check("drain_dout", dout_a, i);
      pop();
    end
    check("drain_empty", empty_a, 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", ovf_a, 0);

    // Push and pop together while full.
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rx_data = 8'h55; rx_valid = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("fullpp_count", cnt_a, 8);
    check("fullpp_ovf", ovf_a, 0);
    check("fullpp_head", dout_a, 8'h11);
    repeat (7) pop();
    check("fullpp_last", dout_a, 8'h55);
    pop();
    check("fullpp_empty", empty_a, 1);

    // Push and pop together while empty.
    rx_data = 8'h3C; rx_valid = 1'b1; rd_en = 1'b1;
    tick();
    rx_valid = 1'b0; rd_en = 1'b0;
    check("emptypp_count", cnt_a, 1);
    check("emptypp_dout", dout_a, 8'h3C);
    pop();
    check("emptypp_empty", empty_a, 1);

    // Errored bytes: stored with flags in A, dropped and counted in B.
    push_byte(8'h11, 1'b0, 1'b0);
    push_byte(8'h22, 1'b0, 1'b1);
    push_byte(8'h33, 1'b1, 1'b0);
    check("drop_count_b", cnt_b, 1);
    check("drop_dout_b", dout_b, 8'h11);
    check("drop_err_b", err_b, 2);
    check("keep_count_a", cnt_a, 3);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_err_b", err_b, 0);
    rx_data = 8'h44; rx_perror = 1'b1; rx_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    rx_valid = 1'b0; rx_perror = 1'b0; clr_ovf = 1'b0;
    check("clr_vs_drop", err_b, 1);
    pop();
    check("keep_dout_a", dout_a, 8'h22);
    check("keep_perr_a", pe_a, 1);
    pop();
    check("keep_ferr_a", fe_a, 1);
    repeat (2) pop();
    check("keep_empty_a", empty_a, 1);

    // Asynchronous reset mid-cycle with buffered data and overflow set.
    for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_ovf", ovf_a, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_empty", empty_a, 1);
    check("arst_count", cnt_a, 0);
    check("arst_ovf", ovf_a, 0);
    check("arst_err_b", err_b, 0);
    check("arst_dout", dout_a, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each byte the receiver reports via Rx_DATA/Rx_VALID, together with its framing and parity error flags, into a circular FIFO.
- Presents the buffered bytes to the consuming logic (display/command decoder) through a first-word-fall-through read port.
- Decouples the receiver's one-shot valid indication from the consumer's read pace and reports overflow.

Parameters:
- DEPTH, 8, number of entries; power of 2, minimum 2.
- DROP_ERR, 0, when 1 bytes flagged with FERROR or PERROR are discarded and counted instead of stored.

Ports:
- clk  input  1  system clock, same clock as the UART receiver.
- reset  input  1  asynchronous, active-low reset.
- Rx_DATA  input  8  received byte from the receiver.
- Rx_VALID  input  1  receiver data-valid level; may stay high for many clk cycles per byte.
- Rx_FERROR  input  1  framing error for the current byte.
- Rx_PERROR  input  1  parity error for the current byte.
- rd_en  input  1  consumer pop request.
- clr_ovf  input  1  clears overflow and err_count.
- dout  output  8  head-of-FIFO byte.
- dout_ferror  output  1  framing flag stored with the head byte.
- dout_perror  output  1  parity flag stored with the head byte.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: a byte was lost because the FIFO was full.
- err_count  output  8  saturating count of discarded errored bytes (DROP_ERR=1 only; otherwise stays 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, count, overflow, err_count and the valid_q edge register clear to 0.
  - empty=1, full=0, dout/dout_ferror/dout_perror=0.
  - Storage contents are don't-care.
- Push detect:
  - push = Rx_VALID & ~valid_q; valid_q <= Rx_VALID each cycle.
  - Exactly one push per rising edge of Rx_VALID, regardless of how long it stays high.
  - Rx_VALID high on the first clock after reset release counts as one push.
- Entry format: {Rx_PERROR, Rx_FERROR, Rx_DATA}, 10 bits, all sampled in the push cycle.
- Error filtering: if DROP_ERR=1 and (FERROR|PERROR) on a push:
  - Entry is not written.
  - err_count increments, saturating at 255.
  - Overflow logic is not evaluated for that byte.
- Write:
  - An accepted push writes at wr_ptr at the clock edge; wr_ptr increments modulo DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Read:
  - FWFT: dout presents the entry at rd_ptr whenever empty=0. Combinational from the storage array; no added latency.
  - rd_en with empty=0 advances rd_ptr at the edge.
  - rd_en with empty=1 is ignored; no state change.
- Latency: a byte pushed at edge N is visible on dout with empty=0 after edge N (same cycle as the count update).
- Full:
  - A push with full=1 and no simultaneous pop is dropped and sets overflow=1. Stored data is untouched.
  - A push and a pop in the same cycle while full are both performed; count stays DEPTH and no overflow occurs.
- Empty: a push and rd_en in the same cycle while empty: the push is performed and rd_en is ignored; count becomes 1.
- count:
  - +1 on push-only, -1 on pop-only, unchanged on both or neither.
  - empty = (count==0); full = (count==DEPTH). Both are registered-consistent with count.
- clr_ovf:
  - Synchronous; clears overflow and err_count next edge.
  - If an overflow or drop event occurs in the same cycle, the event wins: overflow=1, err_count=1.
- Reset mid-operation discards all buffered bytes immediately.
- No state machine beyond the pointer/count datapath; the only sequential control is the edge detect plus the full/empty arbitration above.

Decomposition:
- Shared package uart_pkg:
  - RX_ENTRY_W=10 and the bit-field positions (PERR_BIT=9, FERR_BIT=8).
  - ERR_CNT_W=8.
  - The pointer-width function.
- One natural sub-module: rx_valid_edge (valid_q register plus push pulse). It is reusable for the transmitter's done flag.
- The FIFO core stays in uart_rx_fifo.

Test Plan:
- Reset, then Rx_VALID held high 40 cycles with Rx_DATA=8'hA5 -> count=1, dout=8'hA5, dout_ferror=0, dout_perror=0; no duplicate entries.
- Push 0x01..0x08 (DEPTH=8), then push 0x09 -> full=1, overflow=1, count=8. Popping 8 times returns 0x01..0x08 in order, then empty=1.
- Full FIFO, push 0x55 and rd_en in the same cycle -> count stays 8, overflow stays 0, last pop returns 0x55.
- Empty FIFO, push 0x3C with rd_en=1 in the same cycle -> count=1, dout=0x3C. A following rd_en -> empty=1.
- DROP_ERR=1: push 0x11 (clean), 0x22 with PERROR=1, 0x33 with FERROR=1 -> count=1, dout=0x11, err_count=2. clr_ovf -> err_count=0.
- Three entries queued, then assert reset low mid-cycle -> empty=1, count=0, overflow=0 immediately, without waiting for a clock edge.
